// File: rtl/rf_wb_arbiter_pkg.sv
// Shared constants for the register-file write-back arbiter.
package rf_wb_arbiter_pkg;

   localparam int unsigned AW_DEF       = 5;
   localparam int unsigned DW_DEF       = 32;
   localparam int unsigned NREQ_MAX     = 8;
   localparam int unsigned PEND_W       = 32;
   localparam int unsigned DROP_CNT_MAX = 255;

   // Requester slot assignment
   localparam int unsigned REQ_COREA  = 0;
   localparam int unsigned REQ_COREB  = 1;
   localparam int unsigned REQ_MULDIV = 2;
   localparam int unsigned REQ_LDRET  = 3;

endpackage

// File: rtl/rf_wb_arbiter_rr_pick.sv
// Rotating priority find: first set bit of (req & ~excl) scanning from start upwards, mod N.
module rr_pick #(
   parameter int unsigned N  = 4,
   parameter int unsigned IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] start,
   input  logic [N-1:0]  excl,
   output logic          found,
   output logic [IW-1:0] idx
);

   always_comb begin
      int unsigned pos;
      found = 1'b0;
      idx   = '0;
      pos   = 0;
      for (int k = 0; k < int'(N); k++) begin
         pos = (32'(start) + 32'(k)) % N;
         if (!found && req[pos[IW-1:0]] && !excl[pos[IW-1:0]]) begin
            found = 1'b1;
            idx   = pos[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Dual-port register-file write-back arbiter: round-robin, same-address deferral,
// address-0 writes acknowledged and counted but never issued to a port.
module rf_wb_arbiter
   import rf_wb_arbiter_pkg::*;
#(
   parameter int unsigned NREQ = 4,
   parameter int unsigned AW   = AW_DEF,
   parameter int unsigned DW   = DW_DEF
) (
   input  logic                CLK,
   input  logic                RST_N,
   input  logic                FREEZE,
   input  logic [NREQ-1:0]     REQ_VALID,
   input  logic [NREQ*AW-1:0]  REQ_ADDR,
   input  logic [NREQ*DW-1:0]  REQ_DATA,
   output logic [NREQ-1:0]     REQ_READY,
   output logic                WEA3,
   output logic [AW-1:0]       A3,
   output logic [DW-1:0]       WDA3,
   output logic                WEB3,
   output logic [AW-1:0]       B3,
   output logic [DW-1:0]       WDB3,
   output logic [PEND_W-1:0]   PEND_MASK,
   output logic [7:0]          DROP_CNT
);

   localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [AW-1:0]   addr [NREQ];
   logic [DW-1:0]   data [NREQ];
   logic [NREQ-1:0] zero, cand, excl_b, zero_hs;
   logic [IW-1:0]   rr, a_idx, b_idx;
   logic            a_found, b_found, a_grant, b_grant;
   logic [3:0]      zero_hs_n;
   logic [8:0]      drop_sum;

   always_comb begin
      for (int i = 0; i < int'(NREQ); i++) begin
         addr[i] = REQ_ADDR[i*AW +: AW];
         data[i] = REQ_DATA[i*DW +: DW];
         zero[i] = (addr[i] == '0);
      end
      cand = REQ_VALID & ~zero;
   end

   rr_pick #(.N(NREQ), .IW(IW)) u_pick_a (
      .req   (cand),
      .start (rr),
      .excl  ('0),
      .found (a_found),
      .idx   (a_idx)
   );

   // Port B skips the A winner and anything targeting the same register
   always_comb begin
      for (int i = 0; i < int'(NREQ); i++)
         excl_b[i] = (a_idx == IW'(i)) || (addr[i] == addr[a_idx]);
   end

   rr_pick #(.N(NREQ), .IW(IW)) u_pick_b (
      .req   (cand),
      .start (rr),
      .excl  (excl_b),
      .found (b_found),
      .idx   (b_idx)
   );

   always_comb begin
      a_grant   = a_found && !FREEZE;
      b_grant   = b_found && !FREEZE;
      zero_hs   = REQ_VALID & zero & {NREQ{!FREEZE}};
      zero_hs_n = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
         zero_hs_n    = zero_hs_n + 4'(zero_hs[i]);
         REQ_READY[i] = zero_hs[i] || (a_grant && a_idx == IW'(i))
                                   || (b_grant && b_idx == IW'(i));
      end
      drop_sum = 9'(DROP_CNT) + 9'(zero_hs_n);
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         WEA3     <= 1'b0;
         A3       <= '0;
         WDA3     <= '0;
         WEB3     <= 1'b0;
         B3       <= '0;
         WDB3     <= '0;
         DROP_CNT <= '0;
         rr       <= '0;
      end else begin
         WEA3 <= a_grant;
         WEB3 <= b_grant;
         if (a_grant) begin
            A3   <= addr[a_idx];
            WDA3 <= data[a_idx];
         end
         if (b_grant) begin
            B3   <= addr[b_idx];
            WDB3 <= data[b_idx];
         end
         if (b_grant)
            rr <= IW'((32'(b_idx) + 32'd1) % NREQ);
         else if (a_grant)
            rr <= IW'((32'(a_idx) + 32'd1) % NREQ);
         DROP_CNT <= (drop_sum > 9'(DROP_CNT_MAX)) ? 8'(DROP_CNT_MAX) : drop_sum[7:0];
      end
   end

   always_comb begin
      PEND_MASK = (WEA3 ? (PEND_W'(1) << A3) : '0) | (WEB3 ? (PEND_W'(1) << B3) : '0);
   end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Write-back arbiter for the dual-write-port register file shared by both cores.
- Collects write-back requests from NREQ sources (core A WB, core B WB, multicycle mul/div, load-miss return) and grants up to two per cycle onto write ports A and B.
- Uses round-robin fairness and suppresses same-register conflicts within a cycle.
- Port outputs are registered so the regfile's negedge write sees stable values.

Parameters:
NREQ, 4, number of write-back requesters (2..8)
AW, 5, register address width
DW, 32, data width

Ports:
CLK  input  1  clock, rising edge
RST_N  input  1  asynchronous active-low reset
FREEZE  input  1  global stall; blocks all grants while high
REQ_VALID  input  NREQ  per-requester write request
REQ_ADDR  input  NREQ*AW  packed destination registers; requester i occupies bits [i*AW +: AW]
REQ_DATA  input  NREQ*DW  packed write data; requester i occupies bits [i*DW +: DW]
REQ_READY  output  NREQ  per-requester accept (combinational)
WEA3  output  1  write enable, port A
A3  output  AW  write address, port A
WDA3  output  DW  write data, port A
WEB3  output  1  write enable, port B
B3  output  AW  write address, port B
WDB3  output  DW  write data, port B
PEND_MASK  output  32  one-hot OR of A3/B3 for the active write enables; used by the hazard unit
DROP_CNT  output  8  saturating count of accepted writes to register 0

Behaviour:
- Reset (RST_N low, asynchronous): WEA3=WEB3=0, A3=B3=0, WDA3=WDB3=0, PEND_MASK=0, DROP_CNT=0, round-robin pointer RR=0. Reset takes effect immediately, including mid-transfer; a request pending at reset is not lost, because the requester still holds VALID.
- Requester rule: a requester holds VALID, ADDR and DATA stable until the cycle REQ_READY=1. Handshake = VALID & READY at the rising edge.
- FREEZE=1: REQ_READY=0 for all requesters. The next edge registers WEA3=WEB3=0.
- Address-0 requests: REQ_READY=1 whenever FREEZE=0, without consuming a port. DROP_CNT increments by the number of zero-address handshakes that edge and saturates at 255.
- Port A selection: scan indices RR, RR+1, ... (mod NREQ). The first valid requester with ADDR≠0 wins port A.
- Port B selection: continue the scan after the port A winner. The first valid requester with ADDR≠0 and ADDR≠A winner's ADDR wins port B.
- Same-address requesters after the port A winner are not granted this cycle; they stay pending, which preserves the arbitration order.
- REQ_READY=1 only for the port A winner, the port B winner and zero-address requesters.
- Latency: one cycle. A handshake at edge N drives WEx3/x3/WDx3 during cycle N+1, and the regfile commits at the negedge within N+1.
- Idle cycle (no grant on a port): that port's WE=0 at the next edge; its address and data hold their previous values.
- RR update on the edge after grants:
  - both ports granted: RR = (port B winner + 1) mod NREQ
  - port A only: RR = (port A winner + 1) mod NREQ
  - no grant: RR unchanged
  - wrap-around at NREQ-1 → 0
- PEND_MASK is combinational from the registered outputs: bit A3 set iff WEA3, bit B3 set iff WEB3. Bit 0 is never set.
- Fairness bound: every continuously valid requester is granted within ceil(NREQ/2) non-frozen cycles. The same-address deferral adds at most one cycle per conflicting winner.
- Dual grants never carry the same address, so the regfile sees no write-write collision.

Decomposition:
- Shared package: AW/DW defaults, NREQ_MAX=8, requester index constants (REQ_COREA=0, REQ_COREB=1, REQ_MULDIV=2, REQ_LDRET=3), DROP_CNT_MAX=255.
- One sub-module, rr_pick: a combinational rotate-and-priority-find. Inputs are a request vector, a start pointer and an exclusion mask. Outputs are the found flag and the winner index. It is instantiated twice, once per port; the second instance uses the port A winner plus the same-address matches as its exclusion.

Test Plan:
- Reset mid-grant: drive VALID=4'b0011 (addr 3,5) and pulse RST_N low mid-cycle → WEA3/WEB3 drop to 0 immediately. After release, the next edge gives A3=3, B3=5, PEND_MASK=0x28.
- Round-robin wrap: all four requesters valid with distinct addrs 1,2,3,4, held continuously → grants are (0,1), (2,3), (0,1). RR sequence is 0→2→0.
- Same-address conflict: req0 and req1 both write addr 7 (data 0xAAAA, 0xBBBB) and req2 writes addr 9 → cycle 1 gives A=7/0xAAAA, B=9. Cycle 2 gives A=7/0xBBBB and WEB3=0; the final value of reg7 is 0xBBBB.
- Zero-address drop: req1 addr 0 plus req0 addr 4 → both READY the same cycle, WEA3=1 with A3=4, WEB3=0, DROP_CNT=1. Repeating 300 times gives DROP_CNT=255.
- FREEZE: all valid, FREEZE=1 for 3 cycles → REQ_READY=0 and WE=0 throughout, RR unchanged. Grants resume the cycle after FREEZE=0.
- Single requester: only req3 valid, addr 31, data 0xDEADBEEF → READY the same cycle, next cycle WEA3=1, A3=31, PEND_MASK=0x80000000, and RR becomes 0.
